ebus_io_responder: RTL and testbench

- Generic EBUS device-side responder: the slave end of the conditional-I/O protocol that the EBOX initiates over the multiplexed EBUS.
- Decodes controller select and function, and answers CONO/CONI/DATAO/DATAI with the demand/transfer handshake.
- Drives read data onto the EBUS data mux through its own EBUSdriver pair.
- Holds one 36-bit output buffer and one 36-bit input buffer toward a local device side, and raises a PI request on its assigned channel.
- Base block for DTE20/RH20-style EBUS devices.

---
 rtl/ebus_io_responder_if.sv | 21 ++
 rtl/ebus_io_responder.sv | 177 +++++++++++++++++
 tb/tb_ebus_io_responder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebus_io_responder_if.sv
// EBUS signal bundle between the EBOX (master) and a device-side responder (slave).
// Vectors are numbered [N-1:0]; EBUS bit 0 is the MSB, so EBUS bit n sits at index N-1-n.
interface ebus_io_responder_if;
    logic [6:0]  cs;
    logic [2:0]  func;
    logic        demand;
    logic [35:0] dataIn;
    logic        xfer;
    logic        driving;
    logic [35:0] data;

    modport master (
        output cs, func, demand, dataIn,
        input  xfer, driving, data
    );

    modport slave (
        input  cs, func, demand, dataIn,
        output xfer, driving, data
    );
endinterface

// File: rtl/ebus_io_responder.sv
// Generic EBUS conditional-I/O responder: CONO/CONI/DATAO/DATAI handshake, one output and one
// input buffer toward the local device side, and a PI request on the programmed channel.
module ebus_io_responder #(
    parameter logic [6:0]  DEVCODE    = 7'o040,
    parameter int unsigned XFER_DELAY = 2
) (
    input  logic               clk,
    input  logic               CROBAR,
    ebus_io_responder_if.slave ebus,
    output logic [6:0]         pi_req,
    output logic [35:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [35:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready
);

    typedef enum logic [1:0] {StIdle, StWait, StXfer, StRelease} state_e;

    localparam logic [2:0] FnCono  = 3'd0;
    localparam logic [2:0] FnConi  = 3'd1;
    localparam logic [2:0] FnDatao = 3'd2;
    localparam logic [2:0] FnDatai = 3'd3;
    localparam logic [3:0] CntInit = 4'(XFER_DELAY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  func_q;
    logic [35:0] wdata_q, rdata_q;
    logic [2:0]  pia_q, pia_d;
    logic        done_q, done_d, busy_q, busy_d, error_q, error_d;
    logic        inten_q, inten_d, infull_q, infull_d;
    logic [35:0] obuf_q, obuf_d, ibuf_q, ibuf_d;
    logic [6:0]  pi_req_q, pi_req_d;

    logic        accept, commit, is_read, out_fire, in_fire;
    logic [35:0] coni_word;

    assign accept    = (state_q == StIdle) && ebus.demand && (ebus.cs == DEVCODE) &&
                       (ebus.func <= FnDatai);
    assign commit    = (state_q == StWait) && ebus.demand && (cnt_q == 4'd0);
    assign is_read   = (func_q == FnConi) || (func_q == FnDatai);
    assign out_fire  = busy_q & out_ready;
    assign in_fire   = in_valid & ~infull_q;
    assign coni_word = {28'b0, infull_q, inten_q, error_q, busy_q, done_q, pia_q};

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StWait;
                    cnt_d   = CntInit;
                end
            end
            StWait: begin
                if (!ebus.demand)        state_d = StIdle;
                else if (cnt_q == 4'd0)  state_d = StXfer;
                else                     cnt_d   = cnt_q - 4'd1;
            end
            StXfer:    if (!ebus.demand) state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        ebus.xfer    = 1'b0;
        ebus.driving = 1'b0;
        case (state_q)
            StWait: ebus.driving = is_read;
            StXfer: begin
                ebus.xfer    = 1'b1;
                ebus.driving = is_read;
            end
            default: ;
        endcase
        ebus.data = ebus.driving ? rdata_q : 36'b0;
    end

    // Local-side events are applied last so a hardware set of done beats a CONO clear.
    always_comb begin
        pia_d    = pia_q;
        done_d   = done_q;
        busy_d   = busy_q;
        error_d  = error_q;
        inten_d  = inten_q;
        infull_d = infull_q;
        obuf_d   = obuf_q;
        ibuf_d   = ibuf_q;
        if (commit) begin
            case (func_q)
                FnCono: begin
                    pia_d   = wdata_q[2:0];
                    if (wdata_q[4]) done_d  = 1'b1;
                    if (wdata_q[3]) done_d  = 1'b0;
                    if (wdata_q[5]) error_d = 1'b0;
                    inten_d = wdata_q[6];
                end
                FnDatao: begin
                    if (busy_q) begin
                        error_d = 1'b1;
                    end else begin
                        obuf_d = wdata_q;
                        busy_d = 1'b1;
                    end
                end
                FnDatai: begin
                    if (!infull_q) error_d = 1'b1;
                    infull_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (out_fire) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        if (in_fire) begin
            ibuf_d   = in_data;
            infull_d = 1'b1;
            done_d   = 1'b1;
        end
        pi_req_d = (done_q && inten_q && (pia_q != 3'd0)) ? (7'b1000000 >> (pia_q - 3'd1))
                                                           : 7'b0;
    end

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            func_q   <= 3'd0;
            wdata_q  <= 36'b0;
            rdata_q  <= 36'b0;
            pia_q    <= 3'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
            inten_q  <= 1'b0;
            infull_q <= 1'b0;
            obuf_q   <= 36'b0;
            ibuf_q   <= 36'b0;
            pi_req_q <= 7'b0;
        end else begin
            if (accept) begin
                func_q  <= ebus.func;
                wdata_q <= ebus.dataIn;
                rdata_q <= (ebus.func == FnConi) ? coni_word : ibuf_q;
            end
            pia_q    <= pia_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
            inten_q  <= inten_d;
            infull_q <= infull_d;
            obuf_q   <= obuf_d;
            ibuf_q   <= ibuf_d;
            pi_req_q <= pi_req_d;
        end
    end

    assign pi_req    = pi_req_q;
    assign out_data  = obuf_q;
    assign out_valid = busy_q;
    assign in_ready  = ~infull_q;

endmodule

// File: tb/tb_ebus_io_responder.sv
// Randomized bench for ebus_io_responder against a transaction-level register model.
module tb_ebus_io_responder;

    localparam logic [6:0]  DEVCODE    = 7'o040;
    localparam int unsigned XFER_DELAY = 2;
    localparam int          WINDOW     = 12;

    logic        clk = 1'b0;
    logic        CROBAR;
    logic [6:0]  pi_req;
    logic [35:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] in_data;
    logic        in_valid;
    logic        in_ready;

    ebus_io_responder_if ebus ();

    ebus_io_responder #(
        .DEVCODE   (DEVCODE),
        .XFER_DELAY(XFER_DELAY)
    ) dut (
        .clk      (clk),
        .CROBAR   (CROBAR),
        .ebus     (ebus),
        .pi_req   (pi_req),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: device registers as plain values.
    int unsigned m_pia;
    bit          m_done, m_busy, m_err, m_inten, m_infull;
    logic [35:0] m_obuf, m_ibuf;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_pia = 0; m_done = 0; m_busy = 0; m_err = 0; m_inten = 0; m_infull = 0;
        m_obuf = '0; m_ibuf = '0;
    endfunction

    function automatic logic [35:0] model_coni();
        int unsigned w;
        w = m_pia + 8 * m_done + 16 * m_busy + 32 * m_err + 64 * m_inten + 128 * m_infull;
        return 36'(w);
    endfunction

    function automatic logic [6:0] model_pi();
        if (m_done && m_inten && m_pia != 0) return 7'(1 << (7 - m_pia));
        return 7'b0;
    endfunction

    function automatic void model_commit(input logic [2:0] f, input logic [35:0] wd);
        int unsigned w;
        w = int'(wd[8:0]);
        case (f)
            3'd0: begin
                m_pia = w % 8;
                if ((w / 16) % 2 == 1) m_done = 1;
                if ((w / 8) % 2 == 1)  m_done = 0;
                if ((w / 32) % 2 == 1) m_err  = 0;
                m_inten = ((w / 64) % 2 == 1);
            end
            3'd2: begin
                if (m_busy) m_err = 1;
                else begin m_obuf = wd; m_busy = 1; end
            end
            3'd3: begin
                if (!m_infull) m_err = 1;
                m_infull = 0;
            end
            default: ;
        endcase
    endfunction

    task automatic check_local(input string tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(m_busy));
        check_eq({tag, ".out_data"},  64'(out_data),  64'(m_obuf));
        check_eq({tag, ".in_ready"},  64'(in_ready),  64'(!m_infull));
        check_eq({tag, ".pi_req"},    64'(pi_req),    64'(model_pi()));
    endtask

    // Drive one bus transaction over a fixed window of cycles; cycle 0 is the demand cycle.
    task automatic bus_txn(input logic [6:0] cs, input logic [2:0] f, input logic [35:0] wd,
                           input bit abort, output logic [35:0] rd, output int xcyc,
                           output int drv_cnt, output int xfer_cnt, output int stray);
        bit got_rd = 0;
        rd = '0; xcyc = 0; drv_cnt = 0; xfer_cnt = 0; stray = 0;
        @(posedge clk); #1;
        ebus.cs = cs; ebus.func = f; ebus.dataIn = wd; ebus.demand = 1'b1;
        for (int c = 1; c <= WINDOW; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                ebus.cs     = DEVCODE ^ 7'h55;
                ebus.func   = 3'(4 + $urandom_range(0, 3));
                ebus.dataIn = {4'($urandom), 32'($urandom)};
                if (abort) ebus.demand = 1'b0;
            end
            if (xcyc != 0 && c == xcyc + 1) ebus.demand = 1'b0;
            @(negedge clk);
            if (ebus.xfer) begin
                xfer_cnt++;
                if (xcyc == 0) xcyc = c;
            end
            if (ebus.driving) begin
                drv_cnt++;
                if (!got_rd) begin rd = ebus.data; got_rd = 1; end
                else if (ebus.data !== rd) stray++;
            end else if (ebus.data !== 36'b0) begin
                stray++;
            end
        end
        ebus.demand = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic [6:0] cs, input logic [2:0] f,
                           input logic [35:0] wd, input bit abort, output logic [35:0] rd);
        int  xc, dc, xn, st;
        bit  acc, rdop;
        logic [35:0] exp_rd;
        acc    = (cs == DEVCODE) && (f <= 3'd3);
        rdop   = acc && (f == 3'd1 || f == 3'd3);
        exp_rd = (f == 3'd1) ? model_coni() : m_ibuf;
        bus_txn(cs, f, wd, abort, rd, xc, dc, xn, st);
        check_eq({tag, ".stray"}, 64'(st), 64'd0);
        if (!acc || abort) begin
            check_eq({tag, ".xfer_cnt"}, 64'(xn), 64'd0);
            check_eq({tag, ".drv_cnt"},  64'(dc), (rdop && abort) ? 64'd1 : 64'd0);
        end else begin
            check_eq({tag, ".xfer_cycle"}, 64'(xc), 64'(1 + XFER_DELAY));
            check_eq({tag, ".xfer_cnt"},   64'(xn), 64'd2);
            check_eq({tag, ".drv_cnt"},    64'(dc), rdop ? 64'(XFER_DELAY + 2) : 64'd0);
            if (rdop) check_eq({tag, ".rdata"}, 64'(rd), 64'(exp_rd));
            model_commit(f, wd);
        end
        check_local(tag);
    endtask

    task automatic pulse_out_ready();
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        if (m_busy) begin m_busy = 0; m_done = 1; end
        check_local("out_ready");
    endtask

    task automatic pulse_in_valid(input logic [35:0] d);
        @(posedge clk); #1; in_valid = 1'b1; in_data = d;
        @(posedge clk); #1; in_valid = 1'b0;
        if (!m_infull) begin m_ibuf = d; m_infull = 1; m_done = 1; end
        check_local("in_valid");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [35:0] rd;
        logic [6:0]  bad_cs;
        CROBAR = 1'b1; out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
        ebus.cs = '0; ebus.func = '0; ebus.demand = 1'b0; ebus.dataIn = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 CROBAR = 1'b0;
        @(negedge clk);
        check_eq("rst.xfer",      64'(ebus.xfer),    64'd0);
        check_eq("rst.driving",   64'(ebus.driving), 64'd0);
        check_eq("rst.data",      64'(ebus.data),    64'd0);
        check_eq("rst.pi_req",    64'(pi_req),       64'd0);
        check_eq("rst.out_valid", 64'(out_valid),    64'd0);
        check_eq("rst.out_data",  64'(out_data),     64'd0);
        check_eq("rst.in_ready",  64'(in_ready),     64'd1);
        run_txn("rst_coni", DEVCODE, 3'd1, '0, 0, rd);
        check_eq("rst_coni.word", 64'(rd), 64'o0);

        run_txn("cono125", DEVCODE, 3'd0, 36'o000000000125, 0, rd);
        check_eq("cono125.pi_req", 64'(pi_req), 64'b0000100);
        run_txn("coni115", DEVCODE, 3'd1, '0, 0, rd);
        check_eq("coni115.word", 64'(rd), 64'o115);

        run_txn("datao1", DEVCODE, 3'd2, 36'o123456701234, 0, rd);
        check_eq("datao1.out_data", 64'(out_data), 64'o123456701234);
        run_txn("coni_busy", DEVCODE, 3'd1, '0, 0, rd);
        check_eq("coni_busy.bit31", 64'(rd[4]), 64'd1);
        pulse_out_ready();
        check_eq("drain.done", 64'(m_done), 64'd1);

        run_txn("datao2", DEVCODE, 3'd2, 36'o123456701234, 0, rd);
        run_txn("datao_busy", DEVCODE, 3'd2, 36'o777777777777, 0, rd);
        check_eq("datao_busy.out_data", 64'(out_data), 64'o123456701234);
        run_txn("coni_err", DEVCODE, 3'd1, '0, 0, rd);
        check_eq("coni_err.bit30", 64'(rd[5]), 64'd1);
        run_txn("cono040", DEVCODE, 3'd0, 36'o000000000040, 0, rd);
        run_txn("coni_clr", DEVCODE, 3'd1, '0, 0, rd);
        check_eq("coni_clr.bit30", 64'(rd[5]), 64'd0);
        pulse_out_ready();

        run_txn("abort", DEVCODE, 3'd0, 36'o000000000127, 1, rd);
        run_txn("wrong_cs", 7'o041, 3'd1, '0, 0, rd);
        run_txn("func5", DEVCODE, 3'd5, '0, 0, rd);

        pulse_in_valid(36'o000000001234);
        check_eq("in.in_ready", 64'(in_ready), 64'd0);
        run_txn("datai1", DEVCODE, 3'd3, '0, 0, rd);
        check_eq("datai1.word", 64'(rd), 64'o1234);
        check_eq("datai1.in_ready", 64'(in_ready), 64'd1);
        run_txn("datai2", DEVCODE, 3'd3, '0, 0, rd);
        run_txn("coni_err2", DEVCODE, 3'd1, '0, 0, rd);
        check_eq("coni_err2.bit30", 64'(rd[5]), 64'd1);

        // Reset in the middle of a read with xfer already up.
        @(posedge clk); #1;
        ebus.cs = DEVCODE; ebus.func = 3'd1; ebus.demand = 1'b1;
        repeat (1 + XFER_DELAY) @(posedge clk);
        @(negedge clk);
        check_eq("midrst.xfer_up", 64'(ebus.xfer), 64'd1);
        CROBAR = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst.xfer",    64'(ebus.xfer),    64'd0);
        check_eq("midrst.driving", 64'(ebus.driving), 64'd0);
        CROBAR = 1'b0; ebus.demand = 1'b0;
        model_reset();
        check_local("midrst");

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1: run_txn("r_cono", DEVCODE, 3'd0, {4'($urandom), 32'($urandom)}, 0, rd);
                2: run_txn("r_coni", DEVCODE, 3'd1, '0, 0, rd);
                3: run_txn("r_datao", DEVCODE, 3'd2, {4'($urandom), 32'($urandom)}, 0, rd);
                4: run_txn("r_datai", DEVCODE, 3'd3, '0, 0, rd);
                5: pulse_out_ready();
                6: pulse_in_valid({4'($urandom), 32'($urandom)});
                7: run_txn("r_abort", DEVCODE, 3'($urandom_range(0, 3)),
                           {4'($urandom), 32'($urandom)}, 1, rd);
                8: begin
                    bad_cs = 7'($urandom);
                    if (bad_cs == DEVCODE) bad_cs = bad_cs ^ 7'h01;
                    run_txn("r_badcs", bad_cs, 3'($urandom_range(0, 3)), '0, 0, rd);
                end
                default: run_txn("r_badfn", DEVCODE, 3'($urandom_range(4, 7)), '0, 0, rd);
            endcase
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
